// File: rtl/sma_pkg.sv
// Shared constants and types for the moving-average engine: window lengths,
// reciprocal multipliers and shifts for the constant dividers.
package sma_pkg;

  localparam int NUM_WIN    = 6;
  localparam int HIST_DEPTH = 200;
  localparam int PRICE_W    = 8;
  localparam int SUM_W      = 16;

  localparam int WIN   [NUM_WIN] = '{5, 10, 20, 50, 100, 200};

  // RECIP = ceil(2^SHIFT / WIN) with SHIFT = 16 + clog2(WIN): exact floor for any 16-bit dividend
  localparam int RECIP [NUM_WIN] = '{104858, 104858, 104858, 83887, 83887, 83887};
  localparam int SHIFT [NUM_WIN] = '{19, 20, 21, 22, 23, 24};

  typedef logic [PRICE_W-1:0] price_t;
  typedef logic [SUM_W-1:0]   sum_t;

endpackage

// File: rtl/sma_div_const.sv
// Registered divide-by-constant via reciprocal multiply and shift.
// Define SMA_ROUND_EN for round-to-nearest instead of floor.
module sma_div_const
  import sma_pkg::*;
#(
  parameter int N       = 5,
  parameter int RECIP_M = 104858,
  parameter int SHIFT_S = 19
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  sum_t   sum,
  output price_t q
);

  logic [SUM_W:0] dividend;
  logic [40:0]    prod;
  logic [40:0]    quo;

  always_comb begin
`ifdef SMA_ROUND_EN
    dividend = {1'b0, sum} + (SUM_W+1)'(N / 2);
`else
    dividend = {1'b0, sum};
`endif
    prod = 41'(dividend) * 41'(RECIP_M);
    quo  = prod >> SHIFT_S;
  end

  // Saturation never engages for in-range sums; it only guards the 8-bit result
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      assert (quo <= 41'd255);
      q <= (quo > 41'd255) ? 8'hFF : quo[PRICE_W-1:0];
    end
  end

endmodule

// File: rtl/sma_engine.sv
// Six concurrent moving averages (5..200 samples) over an 8-bit price stream.
// Rounding mode is selected by the SMA_ROUND_EN macro inside sma_div_const.
module sma_engine
  import sma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       price_valid,
  input  logic [7:0] price,
  output logic [7:0] sma_5,
  output logic [7:0] sma_10,
  output logic [7:0] sma_20,
  output logic [7:0] sma_50,
  output logic [7:0] sma_100,
  output logic [7:0] sma_200,
  output logic       sma_valid,
  output logic [5:0] warm
);

  price_t     hist [HIST_DEPTH];
  sum_t       sum  [NUM_WIN];
  price_t     q    [NUM_WIN];
  logic [7:0] count;
  logic [7:0] count_nxt;
  logic       stage_v;

  always_comb begin
    count_nxt = (count == 8'(HIST_DEPTH)) ? count : count + 8'd1;
  end

  // Sums use the pre-shift history, so hist[N-1] is the sample leaving window N
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
      for (int i = 0; i < NUM_WIN; i++) sum[i] <= '0;
      count     <= '0;
      warm      <= '0;
      stage_v   <= 1'b0;
      sma_valid <= 1'b0;
    end else begin
      stage_v   <= price_valid;
      sma_valid <= stage_v;
      if (price_valid) begin
        for (int i = 0; i < NUM_WIN; i++) begin
          sum[i]  <= SUM_W'(({1'b0, sum[i]} + 17'(price)) - 17'(hist[WIN[i]-1]));
          warm[i] <= (count_nxt >= 8'(WIN[i]));
        end
        hist[0] <= price;
        for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
        count <= count_nxt;
      end
    end
  end

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_div
    sma_div_const #(
      .N      (WIN[g]),
      .RECIP_M(RECIP[g]),
      .SHIFT_S(SHIFT[g])
    ) u_div (
      .clk(clk),
      .rst(rst),
      .en (stage_v),
      .sum(sum[g]),
      .q  (q[g])
    );
  end

  assign sma_5   = q[0];
  assign sma_10  = q[1];
  assign sma_20  = q[2];
  assign sma_50  = q[3];
  assign sma_100 = q[4];
  assign sma_200 = q[5];

endmodule

// File: tb/tb_sma_engine.sv
// Bench for sma_engine: queue-based reference averages checked every cycle,
// plus hand-computed literal expectations for key scenarios.
module tb_sma_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       price_valid = 1'b0;
  logic [7:0] price = 8'd0;
  logic [7:0] sma_5, sma_10, sma_20, sma_50, sma_100, sma_200;
  logic       sma_valid;
  logic [5:0] warm;

  sma_engine dut (
    .clk(clk), .rst(rst), .price_valid(price_valid), .price(price),
    .sma_5(sma_5), .sma_10(sma_10), .sma_20(sma_20), .sma_50(sma_50),
    .sma_100(sma_100), .sma_200(sma_200), .sma_valid(sma_valid), .warm(warm)
  );

  always #5 clk = ~clk;

  localparam int W [6] = '{5, 10, 20, 50, 100, 200};

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  logic [7:0] sma_a [6];
  assign sma_a[0] = sma_5;
  assign sma_a[1] = sma_10;
  assign sma_a[2] = sma_20;
  assign sma_a[3] = sma_50;
  assign sma_a[4] = sma_100;
  assign sma_a[5] = sma_200;

  // Reference model: accepted samples newest-first, averages taken at acceptance
  int       hist_q [$];
  int       cnt = 0;
  bit       pend = 1'b0;
  int       pend_sma [6] = '{0, 0, 0, 0, 0, 0};
  int       exp_sma  [6] = '{0, 0, 0, 0, 0, 0};
  bit       exp_valid = 1'b0;
  logic [5:0] exp_warm = 6'b0;

  function automatic int ref_avg(int n);
    int s = 0;
    int r;
    for (int k = 0; k < n && k < hist_q.size(); k++) s += hist_q[k];
`ifdef SMA_ROUND_EN
    r = (s + n / 2) / n;
`else
    r = s / n;
`endif
    return (r > 255) ? 255 : r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist_q.delete();
      cnt = 0;
      pend = 1'b0;
      exp_valid = 1'b0;
      exp_warm = 6'b0;
      for (int i = 0; i < 6; i++) exp_sma[i] = 0;
    end else begin
      exp_valid = pend;
      if (pend) exp_sma = pend_sma;
      pend = price_valid;
      if (price_valid) begin
        hist_q.push_front(int'(price));
        if (hist_q.size() > 200) void'(hist_q.pop_back());
        if (cnt < 200) cnt++;
        for (int i = 0; i < 6; i++) begin
          pend_sma[i] = ref_avg(W[i]);
          exp_warm[i] = (cnt >= W[i]);
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_sma_valid", int'(sma_valid), int'(exp_valid));
      chk("model_warm", int'(warm), int'(exp_warm));
      for (int i = 0; i < 6; i++)
        chk($sformatf("model_sma_%0d", W[i]), int'(sma_a[i]), exp_sma[i]);
    end
  end

  task automatic push(input logic [7:0] v);
    price_valid = 1'b1;
    price = v;
    @(posedge clk);
    #1;
    price_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic lit_all(string tag, int v);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_sma_%0d", tag, W[i]), int'(sma_a[i]), v);
  endtask

  initial begin
    int exp_single [6];
    rst = 1'b1;
    idle(3);
    chk_on = 1'b1;
    lit_all("reset", 0);
    chk("reset_warm", int'(warm), 0);
    chk("reset_valid", int'(sma_valid), 0);
    rst = 1'b0;
    idle(1);

    // single sample 50
    push(8'd50);
    chk("single_valid_early", int'(sma_valid), 0);
    idle(1);
`ifdef SMA_ROUND_EN
    exp_single = '{10, 5, 3, 1, 1, 0};
`else
    exp_single = '{10, 5, 2, 1, 0, 0};
`endif
    chk("single_valid", int'(sma_valid), 1);
    chk("single_warm", int'(warm), 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("single_sma_%0d", W[i]), int'(sma_a[i]), exp_single[i]);

    // constant 100 fill
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      push(8'd100);
      if (k == 4)  chk("warm_after_4", int'(warm), 6'b000000);
      if (k == 5)  chk("warm_after_5", int'(warm), 6'b000001);
      if (k == 99) chk("warm_after_99", int'(warm), 6'b001111);
    end
    chk("warm_after_200", int'(warm), 6'b111111);
    idle(2);
    lit_all("fill100", 100);

    // full-scale then drain
    for (int k = 0; k < 200; k++) push(8'd255);
    idle(2);
    lit_all("full255", 255);
    for (int k = 0; k < 200; k++) push(8'd0);
    idle(2);
    lit_all("drain0", 0);

    // ramp with random gaps
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      push(8'((k - 1) % 255 + 1));
      idle($urandom_range(0, 3));
    end
    idle(2);

    // reset with a sample in flight
    do_reset();
    for (int k = 0; k < 120; k++) push(8'($urandom_range(0, 255)));
    price_valid = 1'b1;
    price = 8'd99;
    @(posedge clk);
    #1;
    rst = 1'b1;
    price = 8'd77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    price_valid = 1'b0;
    lit_all("midrst", 0);
    chk("midrst_warm", int'(warm), 0);
    chk("midrst_valid", int'(sma_valid), 0);
    idle(1);
    chk("midrst_valid_next", int'(sma_valid), 0);
    push(8'd40);
    idle(1);
    chk("after_rst_sma_5", int'(sma_5), 8);
    chk("after_rst_valid", int'(sma_valid), 1);

    // counter saturation
    do_reset();
    for (int k = 0; k < 250; k++) push(8'd10);
    idle(2);
    chk("sat_warm", int'(warm), 6'b111111);
    lit_all("sat10", 10);

    idle(2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
